// File: rtl/sha_pkg.sv
// Shared definitions for the SHA round controller: FSM state encodings,
// standard round counts and the round-index width helper.
package sha_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT     = 3'd1,
    ST_WAIT_BLK = 3'd2,
    ST_PROCESS  = 3'd3,
    ST_DUPD     = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam int unsigned SHA256_ROUNDS = 64;
  localparam int unsigned SHA512_ROUNDS = 80;

  // Width of a round index; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned rounds);
    return (rounds > 1) ? $clog2(rounds) : 1;
  endfunction

endpackage

// File: rtl/sha_round_counter.sv
// Round index counter: clears, or steps by RPC per cycle and wraps to zero
// after the terminal value ROUNDS-RPC.
module sha_round_counter
  import sha_pkg::*;
#(
  parameter int unsigned ROUNDS = SHA256_ROUNDS,
  parameter int unsigned RPC    = 1,
  parameter int unsigned W      = idx_w(ROUNDS)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         step,
  output logic [W-1:0] cnt,
  output logic         term
);

  localparam logic [W-1:0] STEP_V = W'(RPC);
  localparam logic [W-1:0] TERM_V = W'(ROUNDS - RPC);

  logic [W-1:0] cnt_q, cnt_d;

  assign term = (cnt_q == TERM_V);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = term ? '0 : cnt_q + STEP_V;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sha_round_ctrl.sv
// SHA-256/512 compression round sequencer: IV load, block handshake, round
// stepping, digest update and per-message block counting.
module sha_round_ctrl
  import sha_pkg::*;
#(
  parameter int unsigned ROUNDS = SHA256_ROUNDS,
  parameter int unsigned RPC    = 1,
  parameter int unsigned BCNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     block_valid,
  input  logic                     block_last,
  output logic                     block_ready,
  output logic                     init,
  output logic                     ready,
  output logic                     digest_update,
  output logic                     done,
  output logic                     busy,
  output logic [idx_w(ROUNDS)-1:0] round_idx,
  output logic [BCNT_W-1:0]        block_cnt
);

  localparam int unsigned IDX_W = idx_w(ROUNDS);

  if (!(RPC == 1 || RPC == 2 || RPC == 4) || (ROUNDS % RPC != 0) || (ROUNDS < RPC)) begin : g_bad_params
    $error("sha_round_ctrl: RPC must be 1, 2 or 4 and divide ROUNDS");
  end

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic [BCNT_W-1:0]   block_cnt_q, block_cnt_d;
  logic                rnd_clr, rnd_step, rnd_term;

  // Index is held at zero outside PROCESS, so entry into PROCESS always starts at 0.
  assign rnd_step = (state_q == ST_PROCESS);
  assign rnd_clr  = abort || (state_q != ST_PROCESS);

  sha_round_counter #(
    .ROUNDS (ROUNDS),
    .RPC    (RPC),
    .W      (IDX_W)
  ) u_round_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (rnd_clr),
    .step    (rnd_step),
    .cnt     (round_idx),
    .term    (rnd_term)
  );

  assign init          = (state_q == ST_INIT);
  assign block_ready   = (state_q == ST_WAIT_BLK);
  assign ready         = (state_q == ST_PROCESS);
  assign digest_update = (state_q == ST_DUPD);
  assign done          = (state_q == ST_DONE);
  assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign block_cnt     = block_cnt_q;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    block_cnt_d = block_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_INIT;
      end
      ST_INIT: begin
        state_d     = ST_WAIT_BLK;
        block_cnt_d = '0;
        last_d      = 1'b0;
      end
      ST_WAIT_BLK: begin
        if (block_valid && block_ready) begin
          state_d = ST_PROCESS;
          last_d  = block_last;
        end
      end
      ST_PROCESS: begin
        if (rnd_term) state_d = ST_DUPD;
      end
      ST_DUPD: begin
        if (block_cnt_q != '1) block_cnt_d = block_cnt_q + 1'b1;
        state_d = last_q ? ST_DONE : ST_WAIT_BLK;
      end
      ST_DONE: begin
        if (start) state_d = ST_INIT;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b0;
      block_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      block_cnt_q <= block_cnt_d;
    end
  end

endmodule

// File: tb/tb_sha_round_ctrl.sv
// Directed bench for sha_round_ctrl across three parameterisations.
module tb_sha_round_ctrl;

  // Strobe vector bit order: {init, block_ready, ready, digest_update, done, busy}
  localparam int unsigned S_READY = 3;
  localparam int unsigned S_DUPD  = 2;
  localparam int unsigned S_DONE  = 1;

  localparam logic [31:0] V_IDLE = 32'b000000;
  localparam logic [31:0] V_INIT = 32'b100001;
  localparam logic [31:0] V_WAIT = 32'b010001;
  localparam logic [31:0] V_PROC = 32'b001001;
  localparam logic [31:0] V_DUPD = 32'b000101;
  localparam logic [31:0] V_DONE = 32'b000010;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic start_a = 1'b0, abort_a = 1'b0, bv_a = 1'b0, bl_a = 1'b0;
  logic start_b = 1'b0, abort_b = 1'b0, bv_b = 1'b0, bl_b = 1'b0;
  logic start_c = 1'b0, abort_c = 1'b0, bv_c = 1'b0, bl_c = 1'b0;

  logic [5:0]  st_a, st_b, st_c;
  logic [5:0]  idx_a;
  logic [6:0]  idx_b;
  logic [5:0]  idx_c;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sha_round_ctrl #(.ROUNDS(64), .RPC(1), .BCNT_W(16)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort_a),
    .block_valid(bv_a), .block_last(bl_a),
    .block_ready(st_a[4]), .init(st_a[5]), .ready(st_a[3]),
    .digest_update(st_a[2]), .done(st_a[1]), .busy(st_a[0]),
    .round_idx(idx_a), .block_cnt(cnt_a)
  );

  sha_round_ctrl #(.ROUNDS(80), .RPC(4), .BCNT_W(16)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b),
    .block_valid(bv_b), .block_last(bl_b),
    .block_ready(st_b[4]), .init(st_b[5]), .ready(st_b[3]),
    .digest_update(st_b[2]), .done(st_b[1]), .busy(st_b[0]),
    .round_idx(idx_b), .block_cnt(cnt_b)
  );

  sha_round_ctrl #(.ROUNDS(64), .RPC(4), .BCNT_W(2)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .start(start_c), .abort(abort_c),
    .block_valid(bv_c), .block_last(bl_c),
    .block_ready(st_c[4]), .init(st_c[5]), .ready(st_c[3]),
    .digest_update(st_c[2]), .done(st_c[1]), .busy(st_c[0]),
    .round_idx(idx_c), .block_cnt(cnt_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_idx_a(input int idx);
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (st_a[S_READY] && idx_a == 6'(idx)) hit = 1'b1;
    end
    check($sformatf("a_reach_idx_%0d", idx), 32'(hit), 32'd1);
  endtask

  task automatic process_b(input int blk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("b%0d_ready", blk), 32'(st_b), V_PROC);
      check($sformatf("b%0d_idx", blk), 32'(idx_b), 32'(4 * i));
    end
    @(negedge clk);
    check($sformatf("b%0d_dupd", blk), 32'(st_b), V_DUPD);
  endtask

  initial begin
    logic [5:0] seen;
    bit         saw_init;
    bit         pending;
    int         k;
    int         exp_cnt [5] = '{1, 2, 3, 3, 3};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_st_a", 32'(st_a), V_IDLE);
    check("rst_idx_a", 32'(idx_a), 32'd0);
    check("rst_cnt_a", 32'(cnt_a), 32'd0);
    check("rst_st_b", 32'(st_b), V_IDLE);
    check("rst_st_c", 32'(st_c), V_IDLE);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_a", 32'(st_a), V_IDLE);

    // single block, ROUNDS=64 RPC=1
    start_a = 1'b1; bv_a = 1'b1; bl_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check("a_init", 32'(st_a), V_INIT);
    @(negedge clk);
    check("a_wait", 32'(st_a), V_WAIT);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      check("a_ready", 32'(st_a), V_PROC);
      check("a_idx", 32'(idx_a), 32'(i));
    end
    @(negedge clk);
    check("a_dupd", 32'(st_a), V_DUPD);
    check("a_dupd_idx", 32'(idx_a), 32'd0);
    @(negedge clk);
    check("a_done", 32'(st_a), V_DONE);
    check("a_done_cnt", 32'(cnt_a), 32'd1);
    repeat (3) @(negedge clk);
    check("a_done_hold", 32'(st_a), V_DONE);
    check("a_done_hold_cnt", 32'(cnt_a), 32'd1);

    // abort at round 30
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check("a2_init", 32'(st_a), V_INIT);
    check("a2_init_cnt", 32'(cnt_a), 32'd1);
    wait_idx_a(30);
    abort_a = 1'b1;
    @(negedge clk); abort_a = 1'b0;
    check("abort_st", 32'(st_a), V_IDLE);
    check("abort_idx", 32'(idx_a), 32'd0);
    seen = '0;
    repeat (5) begin @(negedge clk); seen |= st_a; end
    check("abort_idle_hold", 32'(seen), V_IDLE);

    // restart after abort; start during PROCESS is ignored
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check("a3_init", 32'(st_a), V_INIT);
    wait_idx_a(10);
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check("start_ign_st", 32'(st_a), V_PROC);
    check("start_ign_idx", 32'(idx_a), 32'd11);
    saw_init = 1'b0;
    for (int i = 0; i < 100 && !st_a[S_DONE]; i++) begin
      @(negedge clk);
      if (st_a[5]) saw_init = 1'b1;
    end
    check("start_ign_noinit", 32'(saw_init), 32'd0);
    check("a3_done", 32'(st_a), V_DONE);
    check("a3_done_cnt", 32'(cnt_a), 32'd1);
    repeat (3) @(negedge clk);
    check("a3_done_hold", 32'(st_a), V_DONE);

    // start + abort together in DONE
    start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk); start_a = 1'b0; abort_a = 1'b0;
    check("sa_idle", 32'(st_a), V_IDLE);
    @(negedge clk);
    check("sa_idle_hold", 32'(st_a), V_IDLE);

    // asynchronous reset mid-PROCESS
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    wait_idx_a(20);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_st", 32'(st_a), V_IDLE);
    check("rst_async_idx", 32'(idx_a), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    seen = '0;
    repeat (5) begin @(negedge clk); seen |= st_a; end
    check("rst_after_idle", 32'(seen), V_IDLE);

    // ROUNDS=80 RPC=4, three blocks with a gap before block 2
    start_b = 1'b1; bv_b = 1'b1; bl_b = 1'b0;
    @(negedge clk); start_b = 1'b0;
    check("b_init", 32'(st_b), V_INIT);
    @(negedge clk);
    check("b_wait1", 32'(st_b), V_WAIT);
    process_b(1);
    bv_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("b_gap_wait", 32'(st_b), V_WAIT);
      if (i == 0) check("b_cnt1", 32'(cnt_b), 32'd1);
      if (i == 5) bv_b = 1'b1;
    end
    process_b(2);
    bl_b = 1'b1;
    @(negedge clk);
    check("b_wait3", 32'(st_b), V_WAIT);
    check("b_cnt2", 32'(cnt_b), 32'd2);
    process_b(3);
    @(negedge clk);
    check("b_done", 32'(st_b), V_DONE);
    check("b_done_cnt", 32'(cnt_b), 32'd3);
    bv_b = 1'b0; bl_b = 1'b0;

    // BCNT_W=2, five blocks: counter saturates at 3
    start_c = 1'b1; bv_c = 1'b1; bl_c = 1'b0;
    k = 0;
    pending = 1'b0;
    for (int i = 0; i < 1000 && k < 5; i++) begin
      @(negedge clk);
      start_c = 1'b0;
      if (st_c[S_DUPD]) begin
        k++;
        if (k == 4) bl_c = 1'b1;
        @(negedge clk);
        check($sformatf("c_cnt_blk%0d", k), 32'(cnt_c), 32'(exp_cnt[k-1]));
        check($sformatf("c_done_blk%0d", k), 32'(st_c[S_DONE]), (k == 5) ? 32'd1 : 32'd0);
        pending = 1'b1;
      end
    end
    check("c_blocks_seen", 32'(k), 32'd5);
    check("c_pending", 32'(pending), 32'd1);
    bv_c = 1'b0; bl_c = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sha_round_ctrl.md
SHA_ROUND_CTRL -- requirements
Module: sha_round_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 64, meaning compression rounds per block (64 for SHA-256, 80 for SHA-512).
REQ-002 SHALL have parameter RPC, default 1, meaning rounds issued per clock (1, 2 or 4).
REQ-003 SHALL have parameter BCNT_W, default 16, meaning width of the processed-block counter.
REQ-004 SHALL have port clk, input, 1, the system clock.
REQ-005 SHALL have port reset_n, input, 1, an asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, a request to begin a new message.
REQ-007 SHALL have port abort, input, 1, a request to cancel the message in progress.
REQ-008 SHALL have port block_valid, input, 1, indicating the upstream 512/1024-bit block is valid.
REQ-009 SHALL have port block_last, input, 1, marking the block as the final block of the message; it is qualified by block_valid.
REQ-010 SHALL have port block_ready, output, 1, indicating the controller accepts a block.
REQ-011 SHALL have port init, output, 1, a strobe that loads the IV into the digest registers.
REQ-012 SHALL have port ready, output, 1, high while rounds are being processed.
REQ-013 SHALL have port digest_update, output, 1, a strobe that adds the working variables to the digest.
REQ-014 SHALL have port done, output, 1, indicating the message digest is valid.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE and DONE.
REQ-016 SHALL have port round_idx, output, clog2(ROUNDS) bits, the first round index of the current cycle.
REQ-017 SHALL have port block_cnt, output, BCNT_W bits, the number of blocks completed in the current message.

Function
REQ-018 SHALL implement the states IDLE, INIT, WAIT_BLK, PROCESS, DUPD and DONE.
REQ-019 SHALL assert init only in INIT, block_ready only in WAIT_BLK, ready only in PROCESS, digest_update only in DUPD, and done only in DONE, all decoded from the registered state.
REQ-020 SHALL transition IDLE->INIT and DONE->INIT when start=1, and otherwise hold the state.
REQ-021 SHALL transition INIT->WAIT_BLK unconditionally after exactly 1 cycle.
REQ-022 SHALL transition WAIT_BLK->PROCESS on handshake (block_valid & block_ready), capture block_last into an internal last flag on that edge, and hold in WAIT_BLK while block_valid=0.
REQ-023 SHALL clear round_idx to 0 on entry to PROCESS and increment it by RPC every PROCESS cycle.
REQ-024 SHALL transition PROCESS->DUPD in the cycle where round_idx == ROUNDS-RPC, so PROCESS lasts exactly ROUNDS/RPC cycles.
REQ-025 SHALL hold DUPD for 1 cycle and increment block_cnt during it, then transition to DONE if the last flag is set and to WAIT_BLK otherwise.
REQ-026 SHALL make block_cnt saturate at all-ones without wrapping, and clear it in INIT.
REQ-027 SHALL give abort priority over all other transitions: any state goes to IDLE on the next edge, the last flag is cleared, and round_idx is cleared.
REQ-028 SHALL ignore start in INIT, WAIT_BLK, PROCESS and DUPD, with no queuing.
REQ-029 SHALL, when start and abort are high in the same cycle in IDLE or DONE, give abort priority and remain in or go to IDLE.
REQ-030 SHALL hold round_idx at 0 outside PROCESS.
REQ-031 SHALL reach DONE no earlier than INIT + WAIT_BLK + ROUNDS/RPC + DUPD = ROUNDS/RPC + 3 cycles after the start is sampled.
REQ-032 SHALL hold done and block_cnt stable in DONE until start or abort.
REQ-033 SHALL generate an elaboration error unless ROUNDS % RPC == 0 and RPC ∈ {1, 2, 4}.
REQ-034 SHALL map any illegal state encoding to IDLE on the next edge.

Reset
REQ-035 SHALL, on reset_n=0, asynchronously force the state to IDLE, round_idx to 0, block_cnt to 0 and the last flag to 0.
REQ-036 SHALL drive all strobes (init, block_ready, ready, digest_update, done, busy) to 0 during reset.
REQ-037 SHALL, when reset is asserted mid-PROCESS, abandon the partial block, produce no digest_update, and require a fresh start afterwards.
REQ-038 SHALL release reset synchronously to clk, which is handled externally.

Structure
REQ-039 SHALL place the state encodings, the SHA-256/SHA-512 round-count constants and the IDX_W function in the shared package sha_pkg.
REQ-040 SHALL use one sub-module, sha_round_counter (a parametrised clear/step-by-RPC counter with a terminal flag), instantiated once.
REQ-041 SHALL keep the FSM combinational next-state logic and the state register in this module.

Verification
REQ-042 SHALL test ROUNDS=64, RPC=1 with one block and block_last=1 held valid, pulsing start: init for 1 cycle, block_ready for 1 cycle, ready for 64 cycles with round_idx 0..63, digest_update for 1 cycle, then done=1 and block_cnt=1.
REQ-043 SHALL test ROUNDS=80, RPC=4 with 3 blocks and a 5-cycle block_valid gap before block 2: ready lasts 20 cycles per block with round_idx 0,4,...,76; WAIT_BLK stretches by 5 cycles; done follows the third digest_update; block_cnt=3.
REQ-044 SHALL test abort asserted at round_idx=30 (ROUNDS=64, RPC=1): next cycle IDLE, with busy=0, ready=0, round_idx=0, no digest_update; start is then accepted normally.
REQ-045 SHALL test reset_n pulsed low mid-PROCESS: all outputs are 0 immediately (asynchronously), and the state is IDLE after release.
REQ-046 SHALL test start pulsed in PROCESS and start+abort pulsed together in DONE: the first is ignored; the second yields IDLE with done=0.
REQ-047 SHALL test BCNT_W=2 with 5 blocks: block_cnt reads 1,2,3,3,3 (saturating), and done asserts after block 5.
